// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with whole-line fill from backing memory.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic        invalidate,
  output logic [31:0] instruction_f,
  output logic        icache_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {StIdle, StFill, StCommit} state_e;

  state_e             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]   fill_tag_q;
  logic [IDX_W-1:0]   fill_index_q;
  logic [OFF_W-1:0]   beat_q;
  logic               inv_seen_q;
  logic               mem_req_q;
  logic [31:0]        mem_addr_q;

  logic [TAG_W-1:0]   pc_tag;
  logic [IDX_W-1:0]   pc_index;
  logic [OFF_W-1:0]   pc_offset;
  logic [OFF_W-1:0]   beat_inc;
  logic               last_beat;
  logic               hit;
  logic               unused_pc;

  assign pc_tag    = pc_f[31 -: TAG_W];
  assign pc_index  = pc_f[OFF_W+2 +: IDX_W];
  assign pc_offset = pc_f[2 +: OFF_W];
  assign unused_pc = ^pc_f[1:0];

  assign beat_inc  = beat_q + OFF_W'(1);
  assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));

  assign hit           = (state_q == StIdle) && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign icache_stall  = !hit;
  assign instruction_f = (state_q == StIdle) ? data_q[pc_index][pc_offset] : '0;
  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      beat_q       <= '0;
      inv_seen_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!hit) begin
            state_q      <= StFill;
            fill_tag_q   <= pc_tag;
            fill_index_q <= pc_index;
            beat_q       <= '0;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= {pc_tag, pc_index, {OFF_W{1'b0}}, 2'b00};
          end
        end
        StFill: begin
          if (mem_ready) begin
            beat_q <= beat_inc;
            if (last_beat) begin
              state_q   <= StCommit;
              mem_req_q <= 1'b0;
            end else begin
              mem_addr_q <= {fill_tag_q, fill_index_q, beat_inc, 2'b00};
            end
          end
        end
        StCommit: begin
          valid_q[fill_index_q] <= !inv_seen_q;
          inv_seen_q            <= 1'b0;
          state_q               <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // A flush must also win over the line being committed this cycle.
      if (invalidate) begin
        valid_q <= '0;
        if (state_q == StFill) inv_seen_q <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits alone gate hits.
  always_ff @(posedge clock) begin
    if (state_q == StFill && mem_ready) data_q[fill_index_q][beat_q] <= mem_rdata;
    if (state_q == StCommit) tag_q[fill_index_q] <= fill_tag_q;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit && hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
      if (state_q == StIdle && !hit && miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: vector table of same-cycle lookups plus fill sequences.
module tb_icache_direct;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        invalidate;
  logic [31:0] instruction_f;
  logic        icache_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int n;

  always #10 clock = ~clock;

  // Backing memory returns address+1; junk when not ready exposes stray writes.
  assign mem_rdata = mem_ready ? (mem_addr + 32'd1) : 32'hDEAD_BEEF;

  icache_direct dut (
    .clock        (clock),
    .reset        (reset),
    .pc_f         (pc_f),
    .invalidate   (invalidate),
    .instruction_f(instruction_f),
    .icache_stall (icache_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        chk_instr;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Counts stall cycles from the current mid-cycle point until the first hit, bounded.
  task automatic wait_fill(output int cnt);
    cnt = 0;
    while (icache_stall && cnt < 100) begin
      cnt++;
      @(posedge clock);
      #4;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #4;
  endtask

  initial begin
    vecs[0] = '{32'h0040_0004, 1'b0, 1'b1, 32'h0040_0005};
    vecs[1] = '{32'h0040_0008, 1'b0, 1'b1, 32'h0040_0009};
    vecs[2] = '{32'h0040_000C, 1'b0, 1'b1, 32'h0040_000D};
    vecs[3] = '{32'h0040_0000, 1'b0, 1'b1, 32'h0040_0001};
    vecs[4] = '{32'h0040_0003, 1'b0, 1'b1, 32'h0040_0001};
    vecs[5] = '{32'h0040_0104, 1'b1, 1'b1, 32'h0040_0005};
    vecs[6] = '{32'h0040_0010, 1'b1, 1'b0, 32'h0000_0000};
    vecs[7] = '{32'h0050_0008, 1'b1, 1'b1, 32'h0040_0009};

    reset      = 1'b1;
    pc_f       = '0;
    invalidate = 1'b0;
    mem_ready  = 1'b0;
    #5;
    chk("reset_req", mem_req, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_stall", icache_stall, 32'd1);
`ifdef ICACHE_STATS_EN
    chk("reset_hits", hit_count, 32'd0);
    chk("reset_misses", miss_count, 32'd0);
`endif
    @(posedge clock);
    @(posedge clock);
    #2;
    reset     = 1'b0;
    pc_f      = 32'h0040_0000;
    mem_ready = 1'b1;
    #2;

    // Cold miss: IDLE miss cycle, four fill beats, commit.
    for (int k = 0; k < 6; k++) begin
      chk("cold_stall", icache_stall, 32'd1);
      chk("cold_req", mem_req, {31'd0, (k >= 1 && k <= 4)});
      if (k >= 1 && k <= 4) chk("cold_addr", mem_addr, 32'h0040_0000 + 32'(4 * (k - 1)));
      cyc();
    end
    chk("cold_hit_stall", icache_stall, 32'd0);
    chk("cold_hit_instr", instruction_f, 32'h0040_0001);

    for (int i = 0; i < 8; i++) begin
      pc_f = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_stall", i), icache_stall, {31'd0, vecs[i].stall});
      if (vecs[i].chk_instr) chk($sformatf("vec%0d_instr", i), instruction_f, vecs[i].instr);
    end
    pc_f = 32'h0040_0000;
    repeat (3) @(posedge clock);
    #4;
`ifdef ICACHE_STATS_EN
    chk("stats_hits", hit_count, 32'd3);
    chk("stats_misses", miss_count, 32'd1);
`endif

    // Conflict miss on index 0 and back again.
    pc_f = 32'h0040_0100;
    #1;
    chk("conflict_miss", icache_stall, 32'd1);
    wait_fill(n);
    chk("conflict_cycles", n, 32'd6);
    chk("conflict_instr", instruction_f, 32'h0040_0101);
    pc_f = 32'h0040_0000;
    #1;
    chk("conflict_back_miss", icache_stall, 32'd1);
    wait_fill(n);
    chk("conflict_back_cycles", n, 32'd6);
    chk("conflict_back_instr", instruction_f, 32'h0040_0001);

    // Backpressure: hold ready low for five cycles at beat 2.
    pc_f = 32'h0040_0020;
    #1;
    cyc();
    chk("bp_beat0_addr", mem_addr, 32'h0040_0020);
    cyc();
    chk("bp_beat1_addr", mem_addr, 32'h0040_0024);
    cyc();
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_hold_req", mem_req, 32'd1);
      chk("bp_hold_addr", mem_addr, 32'h0040_0028);
      chk("bp_hold_stall", icache_stall, 32'd1);
    end
    mem_ready = 1'b1;
    wait_fill(n);
    chk("bp_tail_cycles", n, 32'd3);
    for (int k = 0; k < 4; k++) begin
      pc_f = 32'h0040_0020 + 32'(4 * k);
      #1;
      chk("bp_line_stall", icache_stall, 32'd0);
      chk("bp_line_instr", instruction_f, 32'h0040_0021 + 32'(4 * k));
    end

    // Ready asserted while idle must not disturb the arrays.
    pc_f = 32'h0040_0020;
    repeat (2) cyc();
    chk("idle_ready_instr", instruction_f, 32'h0040_0021);
    chk("idle_ready_req", mem_req, 32'd0);

    // Invalidate coincident with a hit: hit this cycle, miss next.
    invalidate = 1'b1;
    #1;
    chk("inv_idle_hit", icache_stall, 32'd0);
    @(posedge clock);
    #2;
    invalidate = 1'b0;
    #2;
    chk("inv_idle_after", icache_stall, 32'd1);
    wait_fill(n);
    chk("inv_idle_refill_cycles", n, 32'd6);
    chk("inv_idle_refill_instr", instruction_f, 32'h0040_0021);

    // Invalidate pulse during beat 2 of a fill.
    pc_f = 32'h0040_0030;
    #1;
    cyc();
    cyc();
    cyc();
    chk("inv_fill_beat2_addr", mem_addr, 32'h0040_0038);
    invalidate = 1'b1;
    @(posedge clock);
    #2;
    invalidate = 1'b0;
    #2;
    chk("inv_fill_beat3_addr", mem_addr, 32'h0040_003C);
    cyc();
    chk("inv_fill_commit_req", mem_req, 32'd0);
    chk("inv_fill_commit_stall", icache_stall, 32'd1);
    cyc();
    chk("inv_fill_line_invalid", icache_stall, 32'd1);
    chk("inv_fill_idle_req", mem_req, 32'd0);
    pc_f = 32'h0040_0020;
    #1;
    chk("inv_fill_other_line", icache_stall, 32'd1);
    pc_f = 32'h0040_0030;
    #1;
    wait_fill(n);
    chk("inv_fill_refill_cycles", n, 32'd6);
    chk("inv_fill_refill_instr", instruction_f, 32'h0040_0031);

    // Asynchronous reset in the middle of a fill.
    pc_f = 32'h0040_0000;
    #1;
    wait_fill(n);
    chk("ar_prefill_cycles", n, 32'd6);
    pc_f = 32'h0040_0050;
    #1;
    cyc();
    chk("ar_beat0_req", mem_req, 32'd1);
    chk("ar_beat0_addr", mem_addr, 32'h0040_0050);
    cyc();
    #4;
    reset = 1'b1;
    #1;
    chk("ar_req_drop", mem_req, 32'd0);
    chk("ar_addr_clear", mem_addr, 32'd0);
    #1;
    reset = 1'b0;
    pc_f  = 32'h0040_0000;
    #1;
    chk("ar_prior_line_miss", icache_stall, 32'd1);
`ifdef ICACHE_STATS_EN
    chk("ar_hits", hit_count, 32'd0);
    chk("ar_misses", miss_count, 32'd0);
`endif
    pc_f = 32'h0040_0050;
    #1;
    wait_fill(n);
    chk("ar_refill_cycles", n, 32'd6);
    chk("ar_refill_instr", instruction_f, 32'h0040_0051);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage's PC and a slower backing instruction memory.
- On a hit, returns the instruction combinationally in the same cycle.
- On a miss, raises a stall toward the hazard unit (OR'd into StallF/StallD) and fills the whole line from backing memory, one word per accepted beat, before releasing the stall.

Parameters:
- LINES, 16: number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥2.
- Derived widths:
  - IDX_W = clog2(LINES)
  - OFF_W = clog2(WORDS_PER_LINE)
  - TAG_W = 32 - IDX_W - OFF_W - 2

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_f  in  32  fetch PC; bits [1:0] ignored.
- invalidate  in  1  one-cycle pulse; clears all valid bits.
- instruction_f  out  32  instruction at pc_f; valid only when icache_stall=0.
- icache_stall  out  1  miss or fill in progress; feeds the hazard unit.
- mem_req  out  1  backing-memory read request.
- mem_addr  out  32  word-aligned backing-memory address.
- mem_ready  in  1  backing memory returns mem_rdata this cycle.
- mem_rdata  in  32  backing-memory read data.

Behaviour:
- Address split of pc_f: tag = [31:IDX_W+OFF_W+2], index = [IDX_W+OFF_W+1:OFF_W+2], offset = [OFF_W+1:2].
- Storage: per line, one valid bit, TAG_W tag bits, WORDS_PER_LINE data words. Data and tag arrays are not reset; valid bits are.
- Hit = (state==IDLE) && valid[index] && tag_array[index]==tag.
- instruction_f = data[index][offset] whenever state==IDLE, regardless of hit; otherwise 0.
- icache_stall = !hit (combinational). It is 1 throughout FILL.
- Reset values: state=IDLE, all valid=0, mem_req=0, mem_addr=0, beat counter=0. Outputs after reset: icache_stall=1 (any pc misses), instruction_f = array contents (don't care).

FSM states: IDLE, FILL, COMMIT.
- IDLE:
  - On miss, latch fill_tag/fill_index from pc_f, set beat=0, go to FILL.
  - No memory request is issued in the miss cycle; mem_req rises the next cycle.
- FILL:
  - mem_req=1; mem_addr = {fill_tag, fill_index, beat, 2'b00}.
  - On mem_ready=1: write mem_rdata to data[fill_index][beat]; beat++.
  - When beat == WORDS_PER_LINE-1 and mem_ready=1, go to COMMIT.
  - mem_req may stay high for any number of cycles with mem_ready=0 (unbounded wait).
- COMMIT:
  - mem_req=0.
  - tag_array[fill_index] <= fill_tag; valid[fill_index] <= !inv_seen; go to IDLE.
  - Stall remains 1 this cycle. The hit is evaluated in the following IDLE cycle.
- Miss latency: stall for 1 (IDLE miss) + WORDS_PER_LINE ready beats + 1 (COMMIT) cycles minimum. With WORDS_PER_LINE=4 and mem_ready constantly 1, that is 6 stall cycles before the hit.
- mem_req and mem_addr are registered outputs, driven from state and beat.

Boundary conditions:
- pc_f changes during FILL: ignored; the fill completes for the latched address, then the new pc_f is evaluated in IDLE and may miss again.
- mem_ready=1 while not in FILL: ignored; no array write.
- invalidate in IDLE: all valid bits clear at the next edge.
- invalidate during FILL or COMMIT: all valid bits clear; inv_seen is set so the committed line is not marked valid. inv_seen clears on entry to IDLE.
- Simultaneous invalidate and a hit in IDLE: the hit is reported for that cycle; the line is invalid from the next cycle.
- Reset asserted mid-fill: state returns to IDLE immediately (async), mem_req drops to 0 without waiting for a clock, all valid bits clear, and the partial line is discarded.
- Index aliasing: a fill overwrites whichever line previously occupied that index. The old line is lost (no writeback; the cache is read-only).

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds outputs hit_count (out, 32) and miss_count (out, 32), both reset to 0.
  - hit_count increments on every clock edge where hit=1.
  - miss_count increments once per IDLE→FILL transition.
  - Both saturate at 32'hFFFFFFFF; neither wraps.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, pc_f=0x00400000, mem_ready tied 1 with rdata = addr+1 → stall high 6 cycles; mem_addr sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; then instruction_f=0x00400001 with stall=0.
- Hit after fill: pc_f steps through 0x00400004, 0x00400008, 0x0040000C → no stall; instruction_f = 0x00400005, 0x00400009, 0x0040000D.
- Conflict miss: pc_f=0x00400100 (same index, LINES=16) → refill; returning to 0x00400000 misses again.
- Backpressure: mem_ready held 0 for 5 cycles mid-burst → mem_req and mem_addr hold, no array writes; fill resumes and completes correctly.
- Invalidate mid-fill: invalidate pulses during beat 2 → fill completes; the same pc_f misses again afterward.
- Async reset mid-fill: assert reset between edges → mem_req=0 before the next clock edge; after release, the prior line misses. With ICACHE_STATS_EN defined, both counters read 0.
